// File: rtl/popcount_frame_sequencer.sv
// Frame-wide ones/zeros counter that walks a latched frame one WIDTH-bit slice per clock,
// with valid/ready handshakes toward the producer and the consumer.
module popcount_frame_sequencer #(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4,
  localparam int FW    = WIDTH * CHUNKS,
  localparam int CW    = $clog2(WIDTH * CHUNKS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] ones_total,
  output logic [CW-1:0] zeros_total,
  output logic          busy
);

  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [FW-1:0]    r_frame;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_ones_acc;
  logic [CW-1:0]    r_zeros_acc;
  logic [CW-1:0]    r_ones_total;
  logic [CW-1:0]    r_zeros_total;

  logic [WIDTH-1:0] w_slice;
  logic [CW-1:0]    w_slice_ones;
  logic [CW-1:0]    w_slice_zeros;
  logic [CW-1:0]    w_ones_sum;
  logic [CW-1:0]    w_zeros_sum;
  logic             w_accept;
  logic             w_release;
  logic             w_last;

  function automatic logic [CW-1:0] slice_ones(input logic [WIDTH-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{(CW-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic [CW-1:0] slice_zeros(input logic [CW-1:0] ones);
    return CW'(WIDTH) - ones;
  endfunction

  assign w_slice       = r_frame[int'(r_idx) * WIDTH +: WIDTH];
  assign w_slice_ones  = slice_ones(w_slice);
  assign w_slice_zeros = slice_zeros(w_slice_ones);
  assign w_ones_sum    = r_ones_acc + w_slice_ones;
  assign w_zeros_sum   = r_zeros_acc + w_slice_zeros;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_release = out_ready && (r_state == S_DONE);
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Totals are only loaded on the final slice, so a reset mid-frame never exposes a partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame       <= '0;
      r_idx         <= '0;
      r_ones_acc    <= '0;
      r_zeros_acc   <= '0;
      r_ones_total  <= '0;
      r_zeros_total <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_frame     <= in_data;
            r_idx       <= '0;
            r_ones_acc  <= '0;
            r_zeros_acc <= '0;
          end
        end
        S_RUN: begin
          r_ones_acc  <= w_ones_sum;
          r_zeros_acc <= w_zeros_sum;
          if (w_last) begin
            r_idx         <= '0;
            r_ones_total  <= w_ones_sum;
            r_zeros_total <= w_zeros_sum;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign ones_total  = r_ones_total;
  assign zeros_total = r_zeros_total;

endmodule

// File: tb/tb_popcount_frame_sequencer.sv
// Directed bench for popcount_frame_sequencer (WIDTH=8, CHUNKS=4) with an expected-result queue.
module tb_popcount_frame_sequencer;

  localparam int WIDTH  = 8;
  localparam int CHUNKS = 4;
  localparam int FW     = WIDTH * CHUNKS;
  localparam int CW     = $clog2(FW) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] ones_total;
  logic [CW-1:0] zeros_total;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [2*CW-1:0] exp_q[$];

  popcount_frame_sequencer #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ones_total(ones_total), .zeros_total(zeros_total), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [FW-1:0] frame);
    int ones;
    ones = $countones(frame);
    exp_q.push_back({CW'(ones), CW'(FW - ones)});
  endtask

  // Drives a frame into IDLE and returns one step after the accepting edge.
  task automatic send(input string tag, input logic [FW-1:0] frame);
    int guard;
    guard = 0;
    while (!in_ready && guard < 30) begin
      step();
      guard++;
    end
    chk({tag, "_ready_before_accept"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = frame;
    push_exp(frame);
    step();
    chk({tag, "_busy_after_accept"}, int'(busy), 1);
    chk({tag, "_in_ready_low"}, int'(in_ready), 0);
  endtask

  // Waits for out_valid, checks latency from the accept edge and the popped expectation.
  task automatic collect(input string tag);
    int lat;
    logic [2*CW-1:0] e;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, "_in_ready_low_run"}, int'(in_ready), 0);
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, CHUNKS);
    chk({tag, "_in_ready_low_done"}, int'(in_ready), 0);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_ones"}, int'(ones_total), int'(e[2*CW-1:CW]));
      chk({tag, "_zeros"}, int'(zeros_total), int'(e[CW-1:0]));
      chk({tag, "_sum_fw"}, int'(ones_total) + int'(zeros_total), FW);
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, "_out_valid_drop"}, int'(out_valid), 0);
    chk({tag, "_in_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    logic [CW-1:0] held_ones;
    logic [CW-1:0] held_zeros;

    step();
    step();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ones", int'(ones_total), 0);
    chk("rst_zeros", int'(zeros_total), 0);
    rst = 1'b0;
    step();

    // 1: all zeros
    out_ready = 1'b1;
    send("t1", 32'h0000_0000);
    in_valid = 1'b0;
    collect("t1");
    handshake("t1");

    // 2: all ones
    send("t2", 32'hFFFF_FFFF);
    in_valid = 1'b0;
    collect("t2");
    handshake("t2");

    // 3: mixed slices
    send("t3", 32'hF22E_0602);
    in_valid = 1'b0;
    collect("t3");
    handshake("t3");

    // 4: backpressure with in_data/in_valid churn
    out_ready = 1'b0;
    send("t4", 32'h1234_5678);
    in_valid = 1'b0;
    collect("t4");
    held_ones  = ones_total;
    held_zeros = zeros_total;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hFFFF_0000 ^ (32'h0101_0101 * i);
      step();
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_ones", int'(ones_total), int'(held_ones));
      chk("t4_hold_zeros", int'(zeros_total), int'(held_zeros));
      chk("t4_no_accept", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    handshake("t4");
    step();
    chk("t4_idle_no_accept", int'(busy), 0);
    chk("t4_totals_kept", int'(ones_total), int'(held_ones));

    // 5: back-to-back with in_valid held high
    send("t5a", 32'h0000_0001);
    in_data = 32'h8000_0003;
    collect("t5a");
    push_exp(32'h8000_0003);
    handshake("t5a");
    step();
    chk("t5_second_accept", int'(busy), 1);
    in_valid = 1'b0;
    collect("t5b");
    handshake("t5b");

    // 6: reset in RUN at idx=2
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0;
    chk("t6_accepted", int'(busy), 1);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", int'(out_valid), 0);
    chk("t6_rst_in_ready", int'(in_ready), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_ones", int'(ones_total), 0);
    chk("t6_rst_zeros", int'(zeros_total), 0);
    step();
    rst = 1'b0;
    step();
    send("t6", 32'h0F0F_0F0F);
    in_valid = 1'b0;
    collect("t6");
    handshake("t6");

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
